gpio_cfg_serial_loader: RTL and testbench



---
 rtl/gpio_cfg_serial_loader.sv | 157 +++++++++++++++
 tb/tb_gpio_cfg_serial_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_cfg_serial_loader.sv
// Serialises a snapshot of all per-pad GPIO configuration words into the pad
// control daisy chain (MSB of the whole bus first), then strobes serial_load.
module gpio_cfg_serial_loader #(
  parameter int unsigned IO_PADS  = 38,
  parameter int unsigned CFG_BITS = 13,
  parameter int unsigned CLK_DIV  = 2
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [IO_PADS*CFG_BITS-1:0]   cfg_bus,
  input  logic                          xfer_start,
  output logic                          busy,
  output logic                          done,
  output logic                          serial_clock,
  output logic                          serial_data,
  output logic                          serial_load
);

  localparam int unsigned N  = IO_PADS * CFG_BITS;
  localparam int unsigned BW = $clog2(N + 1);

  localparam logic [7:0]    DIV_INIT = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LOAD,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_div, w_div_nxt;
  logic [BW-1:0] r_bit, w_bit_nxt;
  logic [N-1:0]  r_snap, w_snap_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_sclk, w_sclk_nxt;
  logic          r_sdata, w_sdata_nxt;
  logic          r_sload, w_sload_nxt;

  logic          w_div_zero;
  logic [N-1:0]  w_snap_shl;

  assign w_div_zero = (r_div == '0);
  assign w_snap_shl = r_snap << 1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_snap  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_sload <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_snap  <= w_snap_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sdata <= w_sdata_nxt;
      r_sload <= w_sload_nxt;
    end
  end

  // Outputs are computed one cycle ahead so every pin comes straight from a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_snap_nxt  = r_snap;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_sclk_nxt  = r_sclk;
    w_sdata_nxt = r_sdata;
    w_sload_nxt = r_sload;

    case (r_state)
      S_IDLE: begin
        if (xfer_start) begin
          w_state_nxt = S_SHIFT_LO;
          w_div_nxt   = DIV_INIT;
          w_bit_nxt   = '0;
          w_snap_nxt  = cfg_bus;
          w_sdata_nxt = cfg_bus[N-1];
          w_busy_nxt  = 1'b1;
          w_sclk_nxt  = 1'b0;
          w_sload_nxt = 1'b0;
        end
      end

      S_SHIFT_LO: begin
        if (w_div_zero) begin
          w_state_nxt = S_SHIFT_HI;
          w_div_nxt   = DIV_INIT;
          w_sclk_nxt  = 1'b1;
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end

      S_SHIFT_HI: begin
        if (w_div_zero) begin
          w_div_nxt  = DIV_INIT;
          w_sclk_nxt = 1'b0;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = S_LOAD;
            w_sload_nxt = 1'b1;
            w_sdata_nxt = 1'b0;
          end else begin
            // Data advances on the falling edge, giving D cycles of hold and setup.
            w_state_nxt = S_SHIFT_LO;
            w_bit_nxt   = r_bit + BW'(1);
            w_snap_nxt  = w_snap_shl;
            w_sdata_nxt = w_snap_shl[N-1];
          end
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end

      S_LOAD: begin
        if (w_div_zero) begin
          w_state_nxt = S_DONE;
          w_div_nxt   = '0;
          w_sload_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_div_nxt = r_div - 8'd1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign serial_clock = r_sclk;
  assign serial_data  = r_sdata;
  assign serial_load  = r_sload;

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Directed checks of gpio_cfg_serial_loader: a small 2x4, D=1 instance for
// cycle-exact timing and a default-size instance for the full 494-bit stream.
module tb_gpio_cfg_serial_loader;

  localparam int unsigned BIG_N = 38 * 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Small instance
  logic [7:0] s_cfg   = '0;
  logic       s_start = 1'b0;
  logic       s_busy, s_done, s_sclk, s_sdata, s_sload;

  // Default instance
  logic [BIG_N-1:0] b_cfg   = '0;
  logic             b_start = 1'b0;
  logic             b_busy, b_done, b_sclk, b_sdata, b_sload;

  gpio_cfg_serial_loader #(
    .IO_PADS (2),
    .CFG_BITS(4),
    .CLK_DIV (1)
  ) u_small (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cfg_bus     (s_cfg),
    .xfer_start  (s_start),
    .busy        (s_busy),
    .done        (s_done),
    .serial_clock(s_sclk),
    .serial_data (s_sdata),
    .serial_load (s_sload)
  );

  gpio_cfg_serial_loader u_big (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cfg_bus     (b_cfg),
    .xfer_start  (b_start),
    .busy        (b_busy),
    .done        (b_done),
    .serial_clock(b_sclk),
    .serial_data (b_sdata),
    .serial_load (b_sload)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {busy,done,sclk,sdata,load} for cycle c of a small D=1 transfer.
  function automatic logic [4:0] small_exp(input int c, input logic [15:0] sd);
    logic b, d, k, s, l;
    b = (c >= 1 && c <= 17);
    d = (c == 18);
    k = (c >= 1 && c <= 16 && (c % 2 == 0));
    s = (c >= 1 && c <= 16) ? sd[16-c] : 1'b0;
    l = (c == 17);
    return {b, d, k, s, l};
  endfunction

  // Starts a small transfer from an IDLE cycle; returns positioned in the done cycle.
  task automatic run_small(input logic [7:0] cfg, input logic [15:0] sd, input string tag);
    logic [4:0] obs, exp;
    s_cfg   = cfg;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      obs = {s_busy, s_done, s_sclk, s_sdata, s_sload};
      exp = small_exp(c, sd);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d {busy,done,sclk,sdata,load} got %b want %b", tag, c, obs, exp);
      end
      if (c < 18) step();
    end
  endtask

  task automatic test_reset();
    logic [4:0] obs_s, obs_b;
    rst     = 1'b1;
    s_start = 1'b1;
    b_start = 1'b1;
    s_cfg   = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      step();
      obs_s = {s_busy, s_done, s_sclk, s_sdata, s_sload};
      obs_b = {b_busy, b_done, b_sclk, b_sdata, b_sload};
      n_checks++;
      if (obs_s !== 5'b0 || obs_b !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d small got %b big got %b want 00000", c, obs_s, obs_b);
      end
    end
    rst     = 1'b0;
    s_start = 1'b0;
    b_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      obs_s = {s_busy, s_done, s_sclk, s_sdata, s_sload};
      obs_b = {b_busy, b_done, b_sclk, b_sdata, b_sload};
      n_checks++;
      if (obs_s !== 5'b0 || obs_b !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d small got %b big got %b want 00000", c, obs_s, obs_b);
      end
    end
  endtask

  task automatic test_small();
    logic [4:0] obs;
    run_small(8'hA5, 16'b1100_1100_0011_0011, "small_A5");
    // Request in the done cycle must be dropped.
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      obs = {s_busy, s_done, s_sclk, s_sdata, s_sload};
      n_checks++;
      if (obs !== 5'b0) begin
        n_fail++;
        $display("FAIL start_in_done cycle %0d got %b want 00000", c, obs);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    run_small(8'hA5, 16'b1100_1100_0011_0011, "b2b_first");
    step();
    run_small(8'h3C, 16'b0000_1111_1111_0000, "b2b_second");
    step();
  endtask

  task automatic test_snapshot();
    logic [4:0] obs, exp;
    logic [15:0] sd;
    sd      = 16'b1100_1100_0011_0011;
    s_cfg   = 8'hA5;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      obs = {s_busy, s_done, s_sclk, s_sdata, s_sload};
      exp = small_exp(c, sd);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL snapshot cycle %0d got %b want %b", c, obs, exp);
      end
      if (c == 5) begin
        s_cfg   = 8'h5A;
        s_start = 1'b1;
      end
      if (c == 6) s_start = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs, exp;
    logic [15:0] sd;
    sd      = 16'b1100_1100_0011_0011;
    s_cfg   = 8'hA5;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      obs = {s_busy, s_done, s_sclk, s_sdata, s_sload};
      exp = (c <= 9) ? small_exp(c, sd) : 5'b0;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d got %b want %b", c, obs, exp);
      end
      rst = (c == 9);
      step();
    end
    rst = 1'b0;
    run_small(8'h3C, 16'b0000_1111_1111_0000, "after_reset_3C");
    step();
  endtask

  task automatic test_default();
    logic [BIG_N-1:0] saved, cap;
    int nbits, loads, done_cyc, holdbad, cyc;
    logic prev_sclk, prev_sdata, seen;
    for (int i = 0; i < int'(BIG_N); i++) b_cfg[i] = 1'($urandom_range(1, 0));
    saved      = b_cfg;
    cap        = '0;
    nbits      = 0;
    loads      = 0;
    done_cyc   = -1;
    holdbad    = 0;
    prev_sclk  = 1'b0;
    prev_sdata = 1'b0;
    seen       = 1'b0;
    b_start    = 1'b1;
    step();
    b_start = 1'b0;
    cyc     = 1;
    while (!seen && cyc <= 3000) begin
      if (b_sclk && !prev_sclk) begin
        if (nbits < int'(BIG_N)) cap[int'(BIG_N) - 1 - nbits] = b_sdata;
        nbits++;
      end
      if (b_sclk && (b_sdata !== prev_sdata)) holdbad++;
      if (b_sload) loads++;
      if (b_done) begin
        done_cyc = cyc;
        seen     = 1'b1;
      end
      if (cyc == 100) b_cfg = ~b_cfg;
      prev_sclk  = b_sclk;
      prev_sdata = b_sdata;
      if (!seen) begin
        step();
        cyc++;
      end
    end
    n_checks++;
    if (done_cyc !== 1979) begin
      n_fail++;
      $display("FAIL big_done_cycle got %0d want 1979", done_cyc);
    end
    n_checks++;
    if (nbits !== int'(BIG_N)) begin
      n_fail++;
      $display("FAIL big_bit_count got %0d want %0d", nbits, BIG_N);
    end
    n_checks++;
    if (cap !== saved) begin
      n_fail++;
      $display("FAIL big_stream got %h want %h", cap, saved);
    end
    n_checks++;
    if (loads !== 2) begin
      n_fail++;
      $display("FAIL big_load_cycles got %0d want 2", loads);
    end
    n_checks++;
    if (holdbad !== 0) begin
      n_fail++;
      $display("FAIL big_data_while_clk_high got %0d changes want 0", holdbad);
    end
    step();
    n_checks++;
    if ({b_busy, b_done, b_sclk, b_sdata, b_sload} !== 5'b0) begin
      n_fail++;
      $display("FAIL big_idle_after got %b want 00000", {b_busy, b_done, b_sclk, b_sdata, b_sload});
    end
  endtask

  initial begin
    test_reset();
    test_small();
    test_back_to_back();
    test_snapshot();
    test_reset_mid();
    test_default();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
